// File: rtl/multi_mode_ff_bank_if.sv
// Bus bundle for multi_mode_ff_bank: control/data inputs and state outputs.
// master drives the controls and observes state; slave is the flip-flop bank.
interface multi_mode_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_not;
  logic [WIDTH-1:0] changed;
  logic             err;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output en, mode, a, b, load, load_val, clr_err,
    input  q, q_not, changed, err, toggle_cnt
  );

  modport slave (
    input  en, mode, a, b, load, load_val, clr_err,
    output q, q_not, changed, err, toggle_cnt
  );
endinterface

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH flip-flop channels sharing one runtime mode
// (D / T / JK / SR), with synchronous load, clock enable, per-bit change
// flags, a sticky illegal-SR flag and an optional saturating transition
// counter.
// Optional feature macro: MULTI_MODE_FF_TOGGLE_CNT_EN -- when defined the
// popcount and toggle_cnt register are built; otherwise toggle_cnt is 0.

// One channel: next-state function for the shared mode.
module multi_mode_ff_lane (
  input  logic [1:0] mode_i,
  input  logic       q_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       q_next_o,
  output logic       illegal_o
);
  localparam logic [1:0] M_D  = 2'b00;
  localparam logic [1:0] M_T  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;

  // Decode the channel mode; illegal is only meaningful for SR with S=R=1.
  always_comb begin
    q_next_o  = q_i;
    illegal_o = 1'b0;
    case (mode_i)
      M_D:  q_next_o = a_i;
      M_T:  q_next_o = q_i ^ a_i;
      M_JK: begin
        case ({a_i, b_i})
          2'b10:   q_next_o = 1'b1;
          2'b01:   q_next_o = 1'b0;
          2'b11:   q_next_o = ~q_i;
          default: q_next_o = q_i;
        endcase
      end
      default: begin
        case ({a_i, b_i})
          2'b10:   q_next_o = 1'b1;
          2'b01:   q_next_o = 1'b0;
          2'b11:   illegal_o = 1'b1;   // illegal bit keeps its value
          default: q_next_o = q_i;
        endcase
      end
    endcase
  end
endmodule

module multi_mode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_mode_ff_bank_if.slave   bus
);
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] lane_nxt;
  logic [WIDTH-1:0] lane_ill;
  logic             ill_any;

  // Per-channel next-state logic; all lanes see the same mode.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    multi_mode_ff_lane u_lane (
      .mode_i   (bus.mode),
      .q_i      (q_q[i]),
      .a_i      (bus.a[i]),
      .b_i      (bus.b[i]),
      .q_next_o (lane_nxt[i]),
      .illegal_o(lane_ill[i])
    );
  end

  // Priority load > enable > hold; illegal SR only counts on enabled update.
  always_comb begin
    q_d     = q_q;
    ill_any = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
    end else if (bus.en) begin
      q_d     = lane_nxt;
      ill_any = |lane_ill;
    end
    changed_d = q_d ^ q_q;
    // Illegal input in the same cycle beats a clear request.
    err_d     = ill_any | (err_q & ~bus.clr_err);
  end

  // State, change flags and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q       <= RESET_VAL;
      changed_q <= '0;
      err_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_not   = ~q_q;
  assign bus.changed = changed_q;
  assign bus.err     = err_q;

`ifdef MULTI_MODE_FF_TOGGLE_CNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  // Sum wide enough that count + popcount never overflows before clamping.
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;

  // Popcount of this edge's transitions, then saturating accumulate.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(changed_d[i]);
    sum   = SW'(cnt_q) + SW'(pop);
    cnt_d = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Transition counter; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.toggle_cnt = cnt_q;
`else
  assign bus.toggle_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Self-checking bench for multi_mode_ff_bank: directed scenarios with literal
// expectations plus randomized traffic checked against a characteristic-
// equation model every cycle.
module tb_multi_mode_ff_bank;
  localparam int         W  = 8;
  localparam int         CW = 4;
  localparam logic [7:0] RV = 8'hA5;
`ifdef MULTI_MODE_FF_TOGGLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errs   = 0;
  int   checks = 0;

  multi_mode_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  multi_mode_ff_bank #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(RV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model using characteristic equations.
  logic [7:0] mq, mchg;
  bit         merr;
  int         mcnt;

  always @(posedge clk or posedge reset) begin
    logic [7:0] nq;
    bit         ill;
    if (reset) begin
      mq = RV; mchg = '0; merr = 1'b0; mcnt = 0;
    end else begin
      nq  = mq;
      ill = 1'b0;
      if (bus.load) nq = bus.load_val;
      else if (bus.en) begin
        case (bus.mode)
          2'd0: nq = bus.a;
          2'd1: nq = mq ^ bus.a;
          2'd2: nq = (bus.a & ~mq) | (~bus.b & mq);
          default: begin
            nq  = (bus.a & ~bus.b) | (mq & ~(~bus.a & bus.b));
            ill = |(bus.a & bus.b);
          end
        endcase
      end
      mchg = nq ^ mq;
      if (CNT_ON) begin
        mcnt = mcnt + $countones(mchg);
        if (mcnt > (1 << CW) - 1) mcnt = (1 << CW) - 1;
      end
      merr = ill | (merr & !bus.clr_err);
      mq   = nq;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    logic [7:0] mqn;
    #1;
    mqn = ~mq;
    chk("q",          bus.q,          mq);
    chk("q_not",      bus.q_not,      mqn);
    chk("changed",    bus.changed,    mchg);
    chk("err",        bus.err,        merr);
    chk("toggle_cnt", bus.toggle_cnt, mcnt);
  end

  // Returns 2 time units after a rising edge, clear of the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.en = 0; bus.mode = 0; bus.a = 0; bus.b = 0;
    bus.load = 0; bus.load_val = 0; bus.clr_err = 0;
    tick(); tick();
    chk("rst_q", bus.q, 8'hA5);
    chk("rst_qn", bus.q_not, 8'h5A);
    chk("rst_chg", bus.changed, 8'h00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_cnt", bus.toggle_cnt, 0);
    reset = 0;

    // Load from reset value
    bus.load = 1; bus.load_val = 8'h3C;
    tick();
    chk("ld_q", bus.q, 8'h3C);
    chk("ld_chg", bus.changed, 8'h99);
    bus.load = 0;

    // Asynchronous reset mid-cycle
    reset = 1; #1;
    chk("async_q", bus.q, 8'hA5);
    chk("async_qn", bus.q_not, 8'h5A);
    #1 reset = 0;

    // T mode with enable
    bus.load = 1; bus.load_val = 8'h00;
    tick();
    bus.load = 0; bus.mode = 2'b01; bus.a = 8'h0F; bus.en = 1;
    tick(); chk("t1_q", bus.q, 8'h0F); chk("t1_chg", bus.changed, 8'h0F);
    tick(); chk("t2_q", bus.q, 8'h00); chk("t2_chg", bus.changed, 8'h0F);
    tick(); chk("t3_q", bus.q, 8'h0F); chk("t3_chg", bus.changed, 8'h0F);
    bus.en = 0;
    tick(); chk("t4_q", bus.q, 8'h0F); chk("t4_chg", bus.changed, 8'h00);
    tick(); chk("t5_q", bus.q, 8'h0F); chk("t5_chg", bus.changed, 8'h00);

    // JK mode: toggle / set / clear / hold per bit
    bus.load = 1; bus.load_val = 8'hF0;
    tick();
    bus.load = 0; bus.mode = 2'b10; bus.a = 8'b1100_1100; bus.b = 8'b1010_1010; bus.en = 1;
    tick();
    chk("jk_q", bus.q, 8'h5C);
    chk("jk_chg", bus.changed, 8'hAC);

    // SR illegal input and sticky error
    bus.load = 1; bus.load_val = 8'h00; bus.en = 0;
    tick();
    bus.load = 0; bus.mode = 2'b11; bus.a = 8'h81; bus.b = 8'h01; bus.en = 1;
    tick();
    chk("sr_q", bus.q, 8'h80);
    chk("sr_err", bus.err, 1'b1);
    bus.a = 8'h01; bus.b = 8'h01; bus.clr_err = 1;
    tick();
    chk("sr_err_wins", bus.err, 1'b1);
    chk("sr_q_hold", bus.q, 8'h80);
    bus.a = 8'h00; bus.b = 8'h00;
    tick();
    chk("sr_err_clr", bus.err, 1'b0);
    bus.clr_err = 0; bus.en = 0;

    // Counter saturation from a fresh reset
    reset = 1; #1 reset = 0;
    bus.mode = 2'b01; bus.a = 8'hFF; bus.en = 1;
    tick(); chk("cnt1", bus.toggle_cnt, CNT_ON ? 8 : 0);
    tick(); chk("cnt2", bus.toggle_cnt, CNT_ON ? 15 : 0);
    tick(); chk("cnt3", bus.toggle_cnt, CNT_ON ? 15 : 0);

    // Priority: load beats enable, reset beats load
    bus.load = 1; bus.load_val = 8'h42;
    tick();
    chk("pri_load", bus.q, 8'h42);
    reset = 1; #1;
    chk("pri_rst_q", bus.q, 8'hA5);
    chk("pri_rst_cnt", bus.toggle_cnt, 0);
    #1 reset = 0;
    bus.load = 0; bus.en = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      tick();
      reset        = ($urandom_range(0, 39) == 0);
      bus.mode     = 2'($urandom_range(0, 3));
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.load_val = 8'($urandom);
      bus.clr_err  = ($urandom_range(0, 3) == 0);
    end
    tick();
    reset = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
